// File: rtl/fetch_unit_param_if.sv
// Fetch-to-decode and fetch-to-memory signal bundle for fetch_unit_param.
// master = fetch unit side, slave = environment (execute/decode/memory) side.
interface fetch_unit_param_if #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned INSTR_W        = 32,
   parameter int unsigned WORDS_PER_LINE = 4,
   parameter int unsigned CNT_W          = 16
);
   logic [ADDR_W-1:0]                 branch_target;
   logic                              pc_src;
   logic                              dec_ready;
   logic [INSTR_W-1:0]                instruction;
   logic                              instr_valid;
   logic [ADDR_W-1:0]                 pc_out;
   logic [ADDR_W-1:0]                 nextpc;
   logic                              hit;
   logic                              mem_req;
   logic [ADDR_W-1:0]                 mem_addr;
   logic                              mem_ack;
   logic [INSTR_W*WORDS_PER_LINE-1:0] mem_rdata;
   logic [CNT_W-1:0]                  hit_count;
   logic [CNT_W-1:0]                  miss_count;

   modport master (
      input  branch_target, pc_src, dec_ready, mem_ack, mem_rdata,
      output instruction, instr_valid, pc_out, nextpc, hit,
             mem_req, mem_addr, hit_count, miss_count
   );

   modport slave (
      output branch_target, pc_src, dec_ready, mem_ack, mem_rdata,
      input  instruction, instr_valid, pc_out, nextpc, hit,
             mem_req, mem_addr, hit_count, miss_count
   );
endinterface

// File: rtl/fetch_unit_param.sv
// Instruction fetch stage with a direct-mapped I-cache, single-line refill FSM,
// branch redirect (also during refill), decode backpressure and perf counters.
module fetch_unit_param #(
   parameter int unsigned       ADDR_W         = 32,
   parameter int unsigned       INSTR_W        = 32,
   parameter int unsigned       WORDS_PER_LINE = 4,
   parameter int unsigned       NUM_LINES      = 16,
   parameter logic [ADDR_W-1:0] RESET_PC       = '0,
   parameter int unsigned       CNT_W          = 16
) (
   input logic                 clk,
   input logic                 rst,
   fetch_unit_param_if.master  bus
);
   localparam int unsigned BYTES = INSTR_W / 8;
   localparam int unsigned OFF_W = $clog2(BYTES);
   localparam int unsigned WI_W  = $clog2(WORDS_PER_LINE);
   localparam int unsigned LI_W  = $clog2(NUM_LINES);
   localparam int unsigned TAG_W = ADDR_W - OFF_W - WI_W - LI_W;
   localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(BYTES - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BYTES * WORDS_PER_LINE - 1);

   typedef enum logic {S_RUN, S_REQ} state_t;

   state_t               r_state, w_state;
   logic [ADDR_W-1:0]    r_pc, w_pc;
   logic [INSTR_W-1:0]   r_instr, w_instr;
   logic                 r_vout, w_vout;
   logic [ADDR_W-1:0]    r_pc_out, w_pc_out;
   logic                 r_hit, w_hit;
   logic                 r_mem_req, w_mem_req;
   logic [ADDR_W-1:0]    r_mem_addr, w_mem_addr;
   logic [CNT_W-1:0]     r_hit_cnt, w_hit_cnt;
   logic [CNT_W-1:0]     r_miss_cnt, w_miss_cnt;
   logic                 r_redir, w_redir;
   logic [ADDR_W-1:0]    r_redir_pc, w_redir_pc;
   logic                 r_served, w_served;
   logic                 w_fill;

   logic [WORDS_PER_LINE-1:0][INSTR_W-1:0] r_data [NUM_LINES];
   logic [TAG_W-1:0]                       r_tag  [NUM_LINES];
   logic [NUM_LINES-1:0]                   r_lv;

   logic [LI_W-1:0]    w_idx, w_fill_idx;
   logic [WI_W-1:0]    w_sel;
   logic [TAG_W-1:0]   w_tag, w_fill_tag;
   logic               w_lookup_hit, w_slot_free;
   logic [INSTR_W-1:0] w_word;
   logic [ADDR_W-1:0]  w_tgt;

   assign w_idx        = r_pc[OFF_W+WI_W +: LI_W];
   assign w_sel        = r_pc[OFF_W +: WI_W];
   assign w_tag        = r_pc[ADDR_W-1 -: TAG_W];
   assign w_fill_idx   = r_mem_addr[OFF_W+WI_W +: LI_W];
   assign w_fill_tag   = r_mem_addr[ADDR_W-1 -: TAG_W];
   assign w_lookup_hit = r_lv[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_word       = r_data[w_idx][w_sel];
   assign w_slot_free  = !r_vout || bus.dec_ready;
   assign w_tgt        = bus.branch_target & ~OFF_MASK;

   always_comb begin
      w_state    = r_state;
      w_pc       = r_pc;
      w_instr    = r_instr;
      w_vout     = r_vout;
      w_pc_out   = r_pc_out;
      w_hit      = r_hit;
      w_mem_req  = r_mem_req;
      w_mem_addr = r_mem_addr;
      w_hit_cnt  = r_hit_cnt;
      w_miss_cnt = r_miss_cnt;
      w_redir    = r_redir;
      w_redir_pc = r_redir_pc;
      w_served   = r_served;
      w_fill     = 1'b0;
      case (r_state)
         S_RUN: begin
            if (bus.pc_src) begin
               w_pc     = w_tgt;
               w_vout   = 1'b0;
               w_hit    = 1'b0;
               w_served = 1'b0;
            end else if (w_slot_free) begin
               if (w_lookup_hit) begin
                  w_instr  = w_word;
                  w_pc_out = r_pc;
                  w_vout   = 1'b1;
                  // First delivery after a refill is reported as miss-served.
                  w_hit    = !r_served;
                  w_served = 1'b0;
                  w_pc     = r_pc + ADDR_W'(BYTES);
                  if (!r_served && r_hit_cnt != '1)
                     w_hit_cnt = r_hit_cnt + CNT_W'(1);
               end else begin
                  if (r_miss_cnt != '1)
                     w_miss_cnt = r_miss_cnt + CNT_W'(1);
                  w_state    = S_REQ;
                  w_mem_req  = 1'b1;
                  w_mem_addr = r_pc & ~LINE_MASK;
                  if (bus.dec_ready) begin
                     w_vout = 1'b0;
                     w_hit  = 1'b0;
                  end
               end
            end
         end
         S_REQ: begin
            if (bus.pc_src) begin
               w_redir    = 1'b1;
               w_redir_pc = w_tgt;
            end
            if (bus.dec_ready && r_vout) begin
               w_vout = 1'b0;
               w_hit  = 1'b0;
            end
            if (bus.mem_ack) begin
               w_fill    = 1'b1;
               w_mem_req = 1'b0;
               w_state   = S_RUN;
               // A redirect arriving with the ack wins over an older pending one.
               if (bus.pc_src) begin
                  w_pc     = w_tgt;
                  w_redir  = 1'b0;
                  w_served = 1'b0;
               end else if (r_redir) begin
                  w_pc     = r_redir_pc;
                  w_redir  = 1'b0;
                  w_served = 1'b0;
               end else begin
                  w_served = 1'b1;
               end
            end
         end
         default: w_state = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_RUN;
         r_pc       <= RESET_PC;
         r_instr    <= '0;
         r_vout     <= 1'b0;
         r_pc_out   <= '0;
         r_hit      <= 1'b0;
         r_mem_req  <= 1'b0;
         r_mem_addr <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
         r_redir    <= 1'b0;
         r_redir_pc <= '0;
         r_served   <= 1'b0;
         r_lv       <= '0;
      end else begin
         r_state    <= w_state;
         r_pc       <= w_pc;
         r_instr    <= w_instr;
         r_vout     <= w_vout;
         r_pc_out   <= w_pc_out;
         r_hit      <= w_hit;
         r_mem_req  <= w_mem_req;
         r_mem_addr <= w_mem_addr;
         r_hit_cnt  <= w_hit_cnt;
         r_miss_cnt <= w_miss_cnt;
         r_redir    <= w_redir;
         r_redir_pc <= w_redir_pc;
         r_served   <= w_served;
         if (w_fill)
            r_lv[w_fill_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_fill) begin
         r_data[w_fill_idx] <= bus.mem_rdata;
         r_tag[w_fill_idx]  <= w_fill_tag;
      end
   end

   assign bus.instruction = r_instr;
   assign bus.instr_valid = r_vout;
   assign bus.pc_out      = r_pc_out;
   assign bus.nextpc      = r_pc_out + ADDR_W'(BYTES);
   assign bus.hit         = r_hit;
   assign bus.mem_req     = r_mem_req;
   assign bus.mem_addr    = r_mem_addr;
   assign bus.hit_count   = r_hit_cnt;
   assign bus.miss_count  = r_miss_cnt;
endmodule

// File: tb/tb_fetch_unit_param.sv
// Scoreboard bench for fetch_unit_param: directed fetch scenarios push expected
// deliveries; a monitor pops and compares on every accepted decode handshake.
module tb_fetch_unit_param;
   localparam int unsigned AW = 32, IW = 32, WPL = 4, NL = 16, CW = 16;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
      logic        h;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned total = 0;
   int unsigned bad = 0;
   exp_t q[$];

   logic         m_ack = 1'b0;
   logic         inj_ack;
   logic [127:0] m_line = '0;
   int unsigned  m_cnt = 0;
   int unsigned  mem_lat;

   fetch_unit_param_if #(.ADDR_W(AW), .INSTR_W(IW), .WORDS_PER_LINE(WPL), .CNT_W(CW)) bif ();

   fetch_unit_param #(
      .ADDR_W(AW), .INSTR_W(IW), .WORDS_PER_LINE(WPL),
      .NUM_LINES(NL), .RESET_PC(32'h0), .CNT_W(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bif)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [127:0] line_of(input logic [31:0] base);
      logic [127:0] l;
      for (int k = 0; k < 4; k++)
         l[k*32 +: 32] = mem_word(base + 32'(4 * k));
      return l;
   endfunction

   assign bif.mem_ack   = m_ack | inj_ack;
   assign bif.mem_rdata = inj_ack ? {4{32'hDEAD_BEEF}} : m_line;

   // Memory: answers a pending request after mem_lat cycles with a one-cycle ack.
   always @(negedge clk) begin
      if (rst) begin
         m_cnt <= 0;
         m_ack <= 1'b0;
      end else if (m_ack) begin
         m_ack <= 1'b0;
         m_cnt <= 0;
      end else if (bif.mem_req) begin
         if (m_cnt + 1 >= mem_lat) begin
            m_ack  <= 1'b1;
            m_line <= line_of(bif.mem_addr);
         end
         m_cnt <= m_cnt + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic h);
      q.push_back('{pc, mem_word(pc), h});
   endtask

   // kind 0: wait for mem_req at addr a; 1: wait for valid pc_out==a; 2: scoreboard empty
   task automatic wait_for(input int kind, input logic [31:0] a, input string nm);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (kind == 0 && bif.mem_req && bif.mem_addr == a) return;
         if (kind == 1 && bif.instr_valid && bif.pc_out == a) return;
         if (kind == 2 && q.size() == 0) return;
      end
      total++;
      bad++;
      $display("FAIL timeout_%s: got no event want addr %h", nm, a);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (!rst && bif.instr_valid && bif.dec_ready) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_delivery: got pc %h want none", bif.pc_out);
            end else begin
               e = q.pop_front();
               chk("deliver_pc", bif.pc_out, e.pc);
               chk("deliver_instr", bif.instruction, e.ins);
               chk("deliver_hit", 32'(bif.hit), 32'(e.h));
               chk("nextpc", bif.nextpc, e.pc + 32'd4);
            end
         end
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, 32'(bif.instr_valid), 32'd0);
      chk({tag, "_instr"}, bif.instruction, 32'd0);
      chk({tag, "_pc_out"}, bif.pc_out, 32'd0);
      chk({tag, "_hit"}, 32'(bif.hit), 32'd0);
      chk({tag, "_mem_req"}, 32'(bif.mem_req), 32'd0);
      chk({tag, "_mem_addr"}, bif.mem_addr, 32'd0);
      chk({tag, "_hit_cnt"}, 32'(bif.hit_count), 32'd0);
      chk({tag, "_miss_cnt"}, 32'(bif.miss_count), 32'd0);
   endtask

   initial begin
      int unsigned n;
      bif.pc_src        = 1'b0;
      bif.branch_target = '0;
      bif.dec_ready     = 1'b1;
      inj_ack           = 1'b0;
      mem_lat           = 3;
      fork
         monitor();
      join_none

      repeat (2) @(negedge clk);
      chk_zero("reset");

      // Cold start: line 0 fetched, then 0..C streamed, then miss at 0x10.
      push(32'h00, 1'b0);
      push(32'h04, 1'b1);
      push(32'h08, 1'b1);
      push(32'h0C, 1'b1);
      rst = 1'b0;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) begin
            chk("cold_mem_req", 32'(bif.mem_req), 32'd1);
            chk("cold_mem_addr", bif.mem_addr, 32'h0);
            chk("cold_miss_cnt", 32'(bif.miss_count), 32'd1);
         end
         if (bif.instr_valid) begin
            n = i;
            break;
         end
      end
      chk("cold_latency", n, 32'd5);
      wait_for(0, 32'h10, "req10");
      chk("seq_hit_cnt", 32'(bif.hit_count), 32'd3);
      chk("seq_miss_cnt", 32'(bif.miss_count), 32'd2);

      // Decode backpressure holds the presented instruction.
      push(32'h10, 1'b0);
      push(32'h14, 1'b1);
      wait_for(1, 32'h14, "pc14");
      bif.dec_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("hold_valid", 32'(bif.instr_valid), 32'd1);
         chk("hold_pc", bif.pc_out, 32'h14);
         chk("hold_instr", bif.instruction, 32'h5A5A_0014);
         chk("hold_hit", 32'(bif.hit), 32'd1);
         chk("hold_hit_cnt", 32'(bif.hit_count), 32'd4);
      end
      mem_lat = 6;
      push(32'h18, 1'b1);
      push(32'h1C, 1'b1);
      bif.dec_ready = 1'b1;

      // Redirect during refill of 0x20.
      wait_for(0, 32'h20, "req20");
      bif.pc_src        = 1'b1;
      bif.branch_target = 32'h80;
      @(negedge clk);
      bif.pc_src = 1'b0;
      push(32'h80, 1'b0);
      push(32'h84, 1'b1);
      push(32'h88, 1'b1);
      push(32'h8C, 1'b1);
      wait_for(0, 32'h90, "req90");
      chk("redir_hit_cnt", 32'(bif.hit_count), 32'd9);
      chk("redir_miss_cnt", 32'(bif.miss_count), 32'd5);

      // Redirect on a hit cycle with an unaligned target.
      push(32'h90, 1'b0);
      wait_for(1, 32'h90, "pc90");
      bif.pc_src        = 1'b1;
      bif.branch_target = 32'h43;
      @(negedge clk);
      bif.pc_src = 1'b0;
      chk("flush_valid", 32'(bif.instr_valid), 32'd0);
      push(32'h40, 1'b0);
      push(32'h44, 1'b1);
      push(32'h48, 1'b1);
      push(32'h4C, 1'b1);

      // Two redirects during refill of 0x50: the last one wins, target 0x20 hits.
      wait_for(0, 32'h50, "req50");
      chk("flush_hit_cnt", 32'(bif.hit_count), 32'd12);
      chk("flush_miss_cnt", 32'(bif.miss_count), 32'd7);
      bif.pc_src        = 1'b1;
      bif.branch_target = 32'h60;
      @(negedge clk);
      bif.branch_target = 32'h20;
      @(negedge clk);
      bif.pc_src = 1'b0;
      push(32'h20, 1'b1);
      push(32'h24, 1'b1);
      push(32'h28, 1'b1);
      push(32'h2C, 1'b1);
      wait_for(0, 32'h30, "req30");
      chk("last_hit_cnt", 32'(bif.hit_count), 32'd16);
      chk("last_miss_cnt", 32'(bif.miss_count), 32'd8);

      // Reset in the middle of a refill, then a stale ack.
      rst = 1'b1;
      @(negedge clk);
      chk_zero("midreq_reset");
      push(32'h00, 1'b0);
      rst     = 1'b0;
      inj_ack = 1'b1;
      @(negedge clk);
      inj_ack = 1'b0;
      chk("restart_mem_req", 32'(bif.mem_req), 32'd1);
      chk("restart_mem_addr", bif.mem_addr, 32'h0);
      chk("restart_miss_cnt", 32'(bif.miss_count), 32'd1);
      chk("restart_valid", 32'(bif.instr_valid), 32'd0);
      wait_for(2, 32'h0, "drain");
      bif.dec_ready = 1'b0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_unit_param.md
Name: fetch_unit_param

Overview:
- Parametrised instruction-fetch stage with an integrated direct-mapped instruction cache, line-refill state machine and valid/ready handshake to decode.
- Successor to the single-line fetch path: adds synchronous reset, configurable line/cache geometry, miss stall with external memory handshake, branch redirect during refill, decode backpressure and hit/miss counters.
- Sits between the PC/branch logic of the execute stage and the decode stage.

Parameters:
- ADDR_W, 32, byte-address width.
- INSTR_W, 32, instruction width; PC increments by INSTR_W/8.
- WORDS_PER_LINE, 4, instructions per cache line (power of 2, >=2).
- NUM_LINES, 16, cache lines (power of 2).
- RESET_PC, 0, PC value after reset.
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- branch_target  in  ADDR_W  redirect address.
- pc_src  in  1  redirect request; branch_target is taken when 1.
- dec_ready  in  1  decode accepts the current instruction.
- instruction  out  INSTR_W  fetched instruction (registered).
- instr_valid  out  1  instruction/pc_out are valid.
- pc_out  out  ADDR_W  address of the presented instruction.
- nextpc  out  ADDR_W  pc_out + INSTR_W/8 (combinational).
- hit  out  1  registered; 1 when the presented instruction came from a cache hit without a preceding miss.
- mem_req  out  1  line-fill request.
- mem_addr  out  ADDR_W  line-aligned fill address.
- mem_ack  in  1  one-cycle pulse; mem_rdata is valid.
- mem_rdata  in  INSTR_W*WORDS_PER_LINE  fill line; word 0 is in the LSBs.
- hit_count  out  CNT_W  saturating count of hit deliveries.
- miss_count  out  CNT_W  saturating count of misses.

Behaviour:
- Reset (clk edge with rst=1):
  - fetch pc=RESET_PC; state=RUN; all line valid bits=0.
  - instruction=0, instr_valid=0, pc_out=0, hit=0, mem_req=0, mem_addr=0, counters=0, redirect_pending=0.
  - rst overrides all other inputs and aborts any refill in progress; a later mem_ack is ignored.
- Address split:
  - offset = log2(INSTR_W/8) bits.
  - word index = log2(WORDS_PER_LINE) bits.
  - line index = log2(NUM_LINES) bits.
  - tag = remaining upper bits.
  - branch_target low offset bits are forced to 0.
- Output register may load when !instr_valid || dec_ready (slot free).
- State RUN:
  - pc_src=1: pc<=branch_target, instr_valid<=0 (flush). No lookup is counted. This has priority over hit/miss.
  - Else, slot free and lookup hit: instruction<=word, pc_out<=pc, instr_valid<=1, hit<=1, pc<=pc+INSTR_W/8, hit_count++.
  - Else, slot free and miss: miss_count++; state<=REQ; mem_addr<=line-aligned pc; mem_req<=1. If dec_ready, instr_valid<=0.
  - Else (slot not free): hold every output stable.
- State REQ:
  - mem_req held at 1 and mem_addr held stable until mem_ack.
  - On mem_ack: write line data, tag and valid=1; mem_req<=0; state<=RUN.
  - Retry lookup next cycle; it hits, with hit output=0 for that delivery (miss-served). It does not increment hit_count.
  - Miss latency from the miss cycle to instr_valid = mem latency + 2 cycles.
- Redirect during REQ:
  - pc_src=1 sets redirect_pending and latches branch_target (the last one wins).
  - The refill still completes and the line is installed.
  - On return to RUN, pc<=latched target and the stale miss address is not delivered.
  - pc_src and mem_ack in the same cycle: the new target is latched and applied.
- Decode handshake while in REQ:
  - If dec_ready=1 with instr_valid=1, instr_valid<=0.
  - instruction/pc_out remain stable while instr_valid=1 && dec_ready=0.
- PC arithmetic:
  - Wraps modulo 2^ADDR_W.
  - Crossing a line boundary causes a new lookup, which may miss.
- Counters saturate at all-ones and do not wrap.
- hit clears to 0 whenever instr_valid deasserts.

Test Plan:
- Reset then cold start (RESET_PC=0, memory returns the line after 3 cycles) -> mem_req=1, mem_addr=0; instr_valid at cycle 5 with instruction=word0, pc_out=0, hit=0; miss_count=1.
- Sequential run over addresses 0x0..0xC after fill -> four consecutive instructions, pc_out 0,4,8,C, hit=1; then miss at 0x10; hit_count=3.
- dec_ready=0 for 3 cycles with instr_valid=1 -> instruction, pc_out and hit unchanged; pc does not advance.
- pc_src=1 with branch_target=0x43 on a hit cycle -> no delivery that cycle; next delivered pc_out=0x40.
- pc_src pulse with target 0x80 while in REQ for 0x20 -> line 0x20 installed; next delivered pc_out=0x80 (miss); a later fetch of 0x20 hits.
- rst asserted mid-REQ, then stale mem_ack -> all outputs 0; cache stays empty; fetch restarts at RESET_PC.
